cpu_datapath: RTL and testbench

//  32-bit bus-based CPU datapath with general registers, PC/IR, MAR/MDR, on-chip RAM, ALU and branch (CON) logic.

---
 rtl/cpu_datapath_if.sv | 65 ++++++
 rtl/cpu_datapath.sv | 165 ++++++++++++++++
 tb/tb_cpu_datapath.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_datapath_if.sv
// Control/bus interface for cpu_datapath.
// Bundles every strobe driven by the control unit plus the datapath's observable outputs.
//   master : control unit / testbench (drives strobes, opcode, InPortData)
//   slave  : cpu_datapath (drives OutPortData and BusMuxOut)
// Signals:
//   read, write                 RAM read into MDR / RAM write from MDR
//   Gra, Grb, Grc               register-field selects (IR[26:23] / IR[22:19] / IR[18:15])
//   Rin, Rout, BAout            register file load / drive / base-address drive
//   *in strobes                 register loads from the bus (InPortIn loads InPortData)
//   *out strobes                bus drivers
//   incPC                       with Zin, Z <= PC + 1
//   opcode[4:0]                 ALU operation
//   InPortData[31:0]            external input word
//   OutPortData[31:0]           OutPort register
//   BusMuxOut[31:0]             current bus value
interface cpu_datapath_if;
  logic        read;
  logic        write;
  logic        Gra;
  logic        Grb;
  logic        Grc;
  logic        Rin;
  logic        Rout;
  logic        BAout;
  logic        MARin;
  logic        MDRin;
  logic        HIin;
  logic        LOin;
  logic        Yin;
  logic        Zin;
  logic        PCin;
  logic        IRin;
  logic        InPortIn;
  logic        OutPortIn;
  logic        CONN_in;
  logic        HIout;
  logic        LOout;
  logic        ZHighOut;
  logic        ZLowOut;
  logic        MDRout;
  logic        PCout;
  logic        InPortOut;
  logic        Cout;
  logic        incPC;
  logic [4:0]  opcode;
  logic [31:0] InPortData;
  logic [31:0] OutPortData;
  logic [31:0] BusMuxOut;

  modport master (
    output read, write, Gra, Grb, Grc, Rin, Rout, BAout,
    output MARin, MDRin, HIin, LOin, Yin, Zin, PCin, IRin, InPortIn, OutPortIn, CONN_in,
    output HIout, LOout, ZHighOut, ZLowOut, MDRout, PCout, InPortOut, Cout,
    output incPC, opcode, InPortData,
    input  OutPortData, BusMuxOut
  );

  modport slave (
    input  read, write, Gra, Grb, Grc, Rin, Rout, BAout,
    input  MARin, MDRin, HIin, LOin, Yin, Zin, PCin, IRin, InPortIn, OutPortIn, CONN_in,
    input  HIout, LOout, ZHighOut, ZLowOut, MDRout, PCout, InPortOut, Cout,
    input  incPC, opcode, InPortData,
    output OutPortData, BusMuxOut
  );
endinterface

// File: rtl/cpu_datapath.sv
// 32-bit single-bus CPU datapath: R0-R15, PC, IR, MAR, MDR, HI, LO, Y, 64-bit Z, InPort, OutPort,
// CON flag, on-chip RAM and a single-cycle ALU. Every register loads from the shared bus on a
// rising clk edge while its strobe is high.
// Ports:
//   clk  clock, all state updates on the rising edge
//   clr  synchronous active-high reset (RAM contents are kept)
//   dp   cpu_datapath_if.slave: control strobes in, OutPortData / BusMuxOut out
// Parameters:
//   MEM_DEPTH  RAM depth in 32-bit words, addressed by the low MAR bits
//   MEM_FILE   image name, present only when CPU_MEM_INIT_EN is defined
// RAM starts all zeros.
module cpu_datapath #(
`ifdef CPU_MEM_INIT_EN
  parameter string       MEM_FILE  = "ram_init.hex",
`endif
  parameter int unsigned MEM_DEPTH = 512
) (
  input logic           clk,
  input logic           clr,
  cpu_datapath_if.slave dp
);

  localparam int unsigned AddrW = $clog2(MEM_DEPTH);

  logic [31:0] r_q [16];
  logic [31:0] pc_q, ir_q, mar_q, mdr_q, hi_q, lo_q, y_q, inport_q, outport_q;
  logic [63:0] z_q;
  logic        con_q;

  logic [31:0] mem [MEM_DEPTH] = '{default: '0};

  logic [AddrW-1:0] addr;
  logic [3:0]       sel;
  logic [31:0]      c_ext;
  logic [31:0]      bus_val;
  logic             bus_cond;
  logic             cond;
  logic [63:0]      alu_res;
  logic [63:0]      z_d;

  assign addr  = mar_q[AddrW-1:0];
  assign sel   = ({4{dp.Gra}} & ir_q[26:23]) | ({4{dp.Grb}} & ir_q[22:19]) |
                 ({4{dp.Grc}} & ir_q[18:15]);
  assign c_ext = {{13{ir_q[18]}}, ir_q[18:0]};

  // Bus source priority, highest first; register file drivers are the fallback.
  always_comb begin
    bus_val = '0;
    if (dp.MDRout)         bus_val = mdr_q;
    else if (dp.PCout)     bus_val = pc_q;
    else if (dp.ZLowOut)   bus_val = z_q[31:0];
    else if (dp.ZHighOut)  bus_val = z_q[63:32];
    else if (dp.HIout)     bus_val = hi_q;
    else if (dp.LOout)     bus_val = lo_q;
    else if (dp.InPortOut) bus_val = inport_q;
    else if (dp.Cout)      bus_val = c_ext;
    else if (dp.BAout)     bus_val = (sel == 4'd0) ? '0 : r_q[sel];
    else if (dp.Rout)      bus_val = r_q[sel];
  end

  assign dp.BusMuxOut   = bus_val;
  assign dp.OutPortData = outport_q;

  // Branch condition on the current bus value, chosen by IR C2 field.
  always_comb begin
    bus_cond = 1'b0;
    unique case (ir_q[20:19])
      2'b00: bus_cond = (bus_val == 32'd0);
      2'b01: bus_cond = (bus_val != 32'd0);
      2'b10: bus_cond = ~bus_val[31];
      2'b11: bus_cond = bus_val[31];
      default: bus_cond = 1'b0;
    endcase
  end

  // A live CONN_in lets the branch add use this cycle's evaluation instead of the stored flag.
  assign cond = dp.CONN_in ? bus_cond : con_q;

  logic [31:0]        a, b;
  logic [4:0]         sh;
  logic signed [63:0] mul_a, mul_b, mul_p;
  // 33-bit signed division so that -2^31 / -1 cannot overflow.
  logic signed [32:0] div_a, div_b, div_q, div_r;

  always_comb begin
    a       = y_q;
    b       = bus_val;
    sh      = b[4:0];
    mul_a   = {{32{a[31]}}, a};
    mul_b   = {{32{b[31]}}, b};
    mul_p   = mul_a * mul_b;
    div_a   = {a[31], a};
    div_b   = {b[31], b};
    div_q   = '0;
    div_r   = '0;
    if (b != 32'd0) begin
      div_q = div_a / div_b;
      div_r = div_a % div_b;
    end
    alu_res = '0;
    case (dp.opcode)
      5'd0:  alu_res = {32'd0, (cond ? a + b : a)};
      5'd1:  alu_res = {32'd0, a + b};
      5'd2:  alu_res = {32'd0, a - b};
      5'd3:  alu_res = mul_p;
      5'd4:  alu_res = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {div_r[31:0], div_q[31:0]};
      5'd5:  alu_res = {32'd0, a >> sh};
      5'd6:  alu_res = {32'd0, a << sh};
      5'd7:  alu_res = {32'd0, $signed(a) >>> sh};
      5'd8:  alu_res = {32'd0, (a >> sh) | (a << (6'd32 - {1'b0, sh}))};
      5'd9:  alu_res = {32'd0, (a << sh) | (a >> (6'd32 - {1'b0, sh}))};
      5'd10: alu_res = {32'd0, a & b};
      5'd11: alu_res = {32'd0, a | b};
      5'd12: alu_res = {32'd0, -b};
      5'd13: alu_res = {32'd0, a ^ b};
      5'd14: alu_res = {32'd0, ~(a | b)};
      5'd15: alu_res = {32'd0, ~b};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    z_d = alu_res;
    if (dp.incPC) z_d = {32'd0, pc_q + 32'd1};
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 16; i++) r_q[i] <= '0;
      pc_q      <= '0;
      ir_q      <= '0;
      mar_q     <= '0;
      mdr_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      y_q       <= '0;
      z_q       <= '0;
      inport_q  <= '0;
      outport_q <= '0;
      con_q     <= 1'b0;
    end else begin
      if (dp.Rin)       r_q[sel]  <= bus_val;
      if (dp.PCin)      pc_q      <= bus_val;
      if (dp.IRin)      ir_q      <= bus_val;
      if (dp.MARin)     mar_q     <= bus_val;
      if (dp.MDRin)     mdr_q     <= dp.read ? mem[addr] : bus_val;
      if (dp.HIin)      hi_q      <= bus_val;
      if (dp.LOin)      lo_q      <= bus_val;
      if (dp.Yin)       y_q       <= bus_val;
      if (dp.Zin)       z_q       <= z_d;
      if (dp.InPortIn)  inport_q  <= dp.InPortData;
      if (dp.OutPortIn) outport_q <= bus_val;
      if (dp.CONN_in)   con_q     <= bus_cond;
    end
  end

  // RAM keeps its contents across clr; a write during clr is suppressed.
  always_ff @(posedge clk) begin
    if (dp.write && !clr) mem[addr] <= mdr_q;
  end

  logic unused_bits;
  assign unused_bits = ^{mar_q[31:AddrW], div_q[32], div_r[32]};

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed plus randomized bench for cpu_datapath. State is observed only through the bus
// (drive strobes) and OutPortData; expectations come from a behavioural model.
module tb_cpu_datapath;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  cpu_datapath_if dp ();

  cpu_datapath dut (
    .clk (clk),
    .clr (clr),
    .dp  (dp)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_mem [512];
  logic        m_con;

  localparam int SMdr = 0, SPc = 1, SZlo = 2, SZhi = 3, SHi = 4, SLo = 5, SIn = 6, SC = 7,
                 SR = 8, SBa = 9, SNone = 10, SPri = 11;

  task automatic idle();
    dp.read = 0; dp.write = 0; dp.Gra = 0; dp.Grb = 0; dp.Grc = 0;
    dp.Rin = 0; dp.Rout = 0; dp.BAout = 0; dp.MARin = 0; dp.MDRin = 0;
    dp.HIin = 0; dp.LOin = 0; dp.Yin = 0; dp.Zin = 0; dp.PCin = 0; dp.IRin = 0;
    dp.InPortIn = 0; dp.OutPortIn = 0; dp.CONN_in = 0; dp.HIout = 0; dp.LOout = 0;
    dp.ZHighOut = 0; dp.ZLowOut = 0; dp.MDRout = 0; dp.PCout = 0; dp.InPortOut = 0;
    dp.Cout = 0; dp.incPC = 0; dp.opcode = 5'd0;
  endtask

  task automatic edge_only();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    edge_only();
    idle();
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Load a word into InPort, then leave InPortOut asserted for the caller's next step.
  task automatic put(input logic [31:0] v);
    dp.InPortData = v;
    dp.InPortIn   = 1;
    tick();
    dp.InPortOut  = 1;
  endtask

  task automatic chk_src(input int src, input string tag, input logic [31:0] exp);
    logic [31:0] v;
    case (src)
      SMdr:  dp.MDRout = 1;
      SPc:   dp.PCout = 1;
      SZlo:  dp.ZLowOut = 1;
      SZhi:  dp.ZHighOut = 1;
      SHi:   dp.HIout = 1;
      SLo:   dp.LOout = 1;
      SIn:   dp.InPortOut = 1;
      SC:    dp.Cout = 1;
      SR:    begin dp.Gra = 1; dp.Rout = 1; end
      SBa:   begin dp.Gra = 1; dp.BAout = 1; end
      SPri:  begin dp.MDRout = 1; dp.PCout = 1; end
      default: ;
    endcase
    #1;
    v = dp.BusMuxOut;
    idle();
    check(tag, {32'd0, v}, {32'd0, exp});
  endtask

  task automatic mem_wr(input logic [31:0] addr, input logic [31:0] data);
    put(addr); dp.MARin = 1; tick();
    put(data); dp.MDRin = 1; tick();
    dp.write = 1; tick();
    m_mem[addr[8:0]] = data;
  endtask

  task automatic alu_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
    put(a); dp.Yin = 1; tick();
    put(b); dp.Zin = 1; dp.opcode = op; tick();
  endtask

  function automatic bit ref_eval(input logic [31:0] v, input logic [1:0] c2);
    case (c2)
      2'd0:    return v == 0;
      2'd1:    return v != 0;
      2'd2:    return v[31] == 1'b0;
      default: return v[31] == 1'b1;
    endcase
  endfunction

  function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input bit cond);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    longint      t;
    logic [63:0] w;
    logic [31:0] lo = 0, hi = 0;
    int          n = int'(b[4:0]);
    case (op)
      5'd0:  lo = cond ? a + b : a;
      5'd1:  lo = a + b;
      5'd2:  lo = a - b;
      5'd3:  begin t = sa * sb; w = t; lo = w[31:0]; hi = w[63:32]; end
      5'd4:  if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
             else begin
               t = sa / sb; w = t; lo = w[31:0];
               t = sa % sb; w = t; hi = w[31:0];
             end
      5'd5:  lo = a >> n;
      5'd6:  lo = a << n;
      5'd7:  begin t = sa >>> n; w = t; lo = w[31:0]; end
      5'd8:  begin w = {a, a}; w = w >> n; lo = w[31:0]; end
      5'd9:  begin w = {a, a}; w = w << n; lo = w[63:32]; end
      5'd10: lo = a & b;
      5'd11: lo = a | b;
      5'd12: lo = 32'd0 - b;
      5'd13: lo = a ^ b;
      5'd14: lo = ~(a | b);
      5'd15: lo = ~b;
      default: lo = 0;
    endcase
    return {hi, lo};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b, ir;
    logic [4:0]  op;
    bit          conn, cnd;
    logic [63:0] exp;

    idle();
    dp.InPortData = 0;
    clr = 1;
    tick(); tick();
    clr = 0;
    m_con = 0;

    // Reset state
    chk_src(SPc, "rst_pc", 0);
    chk_src(SZlo, "rst_zlo", 0);
    chk_src(SZhi, "rst_zhi", 0);
    chk_src(SMdr, "rst_mdr", 0);
    chk_src(SNone, "no_driver", 0);
    check("rst_outport", {32'd0, dp.OutPortData}, 0);

    // Instruction fetch
    mem_wr(0, 32'h9B08_0019);
    put(0); dp.PCin = 1; tick();
    dp.PCout = 1; dp.MARin = 1; dp.Zin = 1; dp.incPC = 1; tick();
    dp.ZLowOut = 1; dp.PCin = 1; dp.read = 1; dp.MDRin = 1; tick();
    dp.MDRout = 1; dp.IRin = 1; tick();
    chk_src(SPc, "fetch_pc", 1);
    chk_src(SMdr, "fetch_mdr", 32'h9B08_0019);
    chk_src(SC, "fetch_c", 25);

    // brnz taken
    put(1); dp.Gra = 1; dp.Rin = 1; tick();
    chk_src(SR, "r6", 1);
    dp.PCout = 1; dp.Yin = 1; tick();
    dp.Cout = 1; dp.Zin = 1; dp.CONN_in = 1; dp.opcode = 0; tick();
    dp.ZLowOut = 1; dp.PCin = 1; tick();
    chk_src(SPc, "brnz_pc", 26);
    alu_op(0, 7, 0);
    chk_src(SZlo, "con_set", 7);

    // brzr not taken
    put(32'h9B00_0019); dp.IRin = 1; tick();
    put(1); dp.PCin = 1; tick();
    dp.PCout = 1; dp.Yin = 1; tick();
    dp.Cout = 1; dp.Zin = 1; dp.CONN_in = 1; tick();
    dp.ZLowOut = 1; dp.PCin = 1; tick();
    chk_src(SPc, "brzr_pc", 1);
    chk_src(SZlo, "brzr_z", 1);
    alu_op(0, 7, 0);
    chk_src(SZlo, "con_clr", 0);

    // mul / div
    alu_op(32'hFFFF_FFFF, 5, 3);
    chk_src(SZlo, "mul_lo", 32'hFFFF_FFFB);
    chk_src(SZhi, "mul_hi", 32'hFFFF_FFFF);
    alu_op(17, 5, 4);
    chk_src(SZlo, "div_q", 3);
    chk_src(SZhi, "div_r", 2);
    alu_op(17, 0, 4);
    chk_src(SZlo, "div0_q", 32'hFFFF_FFFF);
    chk_src(SZhi, "div0_r", 17);
    dp.PCout = 1; dp.Zin = 1; dp.incPC = 1; dp.opcode = 3; tick();
    chk_src(SZlo, "incpc_lo", 2);
    chk_src(SZhi, "incpc_hi", 0);

    // BAout vs Rout on R0
    put(0); dp.IRin = 1; tick();
    put(32'h1234); dp.Gra = 1; dp.Rin = 1; tick();
    chk_src(SBa, "baout_r0", 0);
    chk_src(SR, "rout_r0", 32'h1234);

    // Store, output port, HI/LO, bus priority, held strobe
    mem_wr(5, 32'hABCD);
    chk_src(SPri, "bus_prio", 32'hABCD);
    put(32'hCAFE_F00D); dp.OutPortIn = 1; tick();
    check("outport", {32'd0, dp.OutPortData}, {32'd0, 32'hCAFE_F00D});
    put(32'h1111_2222); dp.HIin = 1; tick();
    put(32'h3333_4444); dp.LOin = 1; tick();
    chk_src(SHi, "hi", 32'h1111_2222);
    chk_src(SLo, "lo", 32'h3333_4444);
    put(9); dp.PCin = 1; edge_only(); edge_only(); idle();
    chk_src(SPc, "pc_hold", 9);

    // clr overrides strobes and a pending RAM write
    put(32'h5555); dp.MDRin = 1; tick();
    clr = 1;
    dp.write = 1; dp.PCin = 1; dp.InPortIn = 1; dp.InPortData = 77; tick();
    clr = 0;
    chk_src(SPc, "clr_pc", 0);
    chk_src(SMdr, "clr_mdr", 0);
    chk_src(SZlo, "clr_zlo", 0);
    chk_src(SHi, "clr_hi", 0);
    chk_src(SIn, "clr_inport", 0);
    chk_src(SC, "clr_ir", 0);
    check("clr_outport", {32'd0, dp.OutPortData}, 0);
    m_con = 0;
    put(5); dp.MARin = 1; tick();
    dp.read = 1; dp.MDRin = 1; tick();
    chk_src(SMdr, "mem_kept", m_mem[5]);

    // Same-edge write and read: MDR gets the old word
    put(32'h1111); dp.MDRin = 1; tick();
    dp.write = 1; dp.read = 1; dp.MDRin = 1; tick();
    chk_src(SMdr, "rw_old", 32'hABCD);
    dp.read = 1; dp.MDRin = 1; tick();
    chk_src(SMdr, "rw_new", 32'h1111);

    // Randomized ALU / branch traffic
    for (int i = 0; i < 150; i++) begin
      ir   = $urandom;
      a    = $urandom;
      b    = $urandom;
      op   = 5'($urandom_range(0, 31));
      conn = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) b = 0;
      if ($urandom_range(0, 15) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      put(ir); dp.IRin = 1; tick();
      put(a); dp.Yin = 1; tick();
      put(b); dp.Zin = 1; dp.opcode = op; dp.CONN_in = conn; tick();
      cnd = conn ? ref_eval(b, ir[20:19]) : m_con;
      if (conn) m_con = cnd;
      exp = ref_alu(op, a, b, cnd);
      chk_src(SZlo, $sformatf("rnd%0d_op%0d_lo", i, op), exp[31:0]);
      chk_src(SZhi, $sformatf("rnd%0d_op%0d_hi", i, op), exp[63:32]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
